// File: rtl/scan_unload_chain.sv
// ---------------------------------------------------------------------------
// scan_unload_chain
//
// Serial unload path for the 3x3 matrix-multiplier result. A capture request
// snapshots the parallel result matrix into a shift register. The matrix then
// shifts out LSB-first on scan_out, element 0 (C[0][0]) first, each time
// scan_enable is high. When no unload is active, scan_enable shifts scan_in
// straight through, so this segment can sit inside a longer daisy chain.
//
// Optional build macro: SCAN_UNLOAD_PARITY_EN
//   When defined, the register gains one bit. An even-parity bit (^result_in)
//   is captured above the data and shifts out last, giving an unload length of
//   TOTAL_W+1 instead of TOTAL_W.
//
// Ports:
//   Clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high; aborts any unload in progress
//   capture_req  single-cycle request to snapshot result_in
//   result_in    parallel result; element k at [k*ELEM_W +: ELEM_W]
//   scan_enable  advances the shift register by one bit
//   scan_in      serial input from the upstream segment, enters at the MSB
//   scan_out     serial output, always the register LSB
//   busy         high while an unload is in progress
//   done         one-cycle pulse after the final bit has shifted
//   overrun      sticky flag, set by a capture request made while busy
// ---------------------------------------------------------------------------
module scan_unload_chain #(
  parameter int ELEM_W  = 18,
  parameter int N_ELEM  = 9,
  parameter int TOTAL_W = N_ELEM * ELEM_W
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               capture_req,
  input  logic [TOTAL_W-1:0] result_in,
  input  logic               scan_enable,
  input  logic               scan_in,
  output logic               scan_out,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

`ifdef SCAN_UNLOAD_PARITY_EN
  localparam int L = TOTAL_W + 1;
`else
  localparam int L = TOTAL_W;
`endif

  localparam int               CNT_W = $clog2(L + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(L - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [L-1:0]     shreg;
  logic [CNT_W-1:0] count;
  logic             overrun_q;

  // Word loaded into the shift register on capture.
  function automatic logic [L-1:0] capture_word(input logic [TOTAL_W-1:0] d);
`ifdef SCAN_UNLOAD_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  always_ff @(posedge Clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        // DONE lasts one cycle and otherwise behaves exactly like IDLE,
        // so a back-to-back capture is accepted without flagging overrun.
        IDLE, DONE: begin
          if (capture_req) begin
            shreg <= capture_word(result_in);
            count <= '0;
            state <= SHIFT;
          end else begin
            if (scan_enable) begin
              shreg <= {scan_in, shreg[L-1:1]};
            end
            state <= IDLE;
          end
        end
        SHIFT: begin
          // A capture here would corrupt the unload, so it is dropped and
          // only recorded.
          if (capture_req) begin
            overrun_q <= 1'b1;
          end
          if (scan_enable) begin
            shreg <= {scan_in, shreg[L-1:1]};
            if (count == LAST) begin
              count <= '0;
              state <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign scan_out = shreg[0];
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_scan_unload_chain.sv
// ---------------------------------------------------------------------------
// tb_scan_unload_chain
//
// Directed bench for scan_unload_chain: reset, bypass shifting, full unloads
// of hand-chosen matrices, pause, overrun, abort by reset and, when built
// with SCAN_UNLOAD_PARITY_EN, the trailing parity bit.
// ---------------------------------------------------------------------------
module tb_scan_unload_chain;

  localparam int ELEM_W  = 18;
  localparam int N_ELEM  = 9;
  localparam int TOTAL_W = N_ELEM * ELEM_W;
`ifdef SCAN_UNLOAD_PARITY_EN
  localparam int L = TOTAL_W + 1;
`else
  localparam int L = TOTAL_W;
`endif

  logic               Clock = 1'b0;
  logic               reset = 1'b1;
  logic               capture_req = 1'b0;
  logic [TOTAL_W-1:0] result_in = '0;
  logic               scan_enable = 1'b0;
  logic               scan_in = 1'b0;
  logic               scan_out;
  logic               busy;
  logic               done;
  logic               overrun;

  int tests = 0;
  int fails = 0;

  logic [L-1:0] last_stream;

  always #5 Clock = ~Clock;

  scan_unload_chain #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) dut (
    .Clock       (Clock),
    .reset       (reset),
    .capture_req (capture_req),
    .result_in   (result_in),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [L-1:0] expected_stream(input logic [TOTAL_W-1:0] d);
`ifdef SCAN_UNLOAD_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic start_capture(input logic [TOTAL_W-1:0] d, input logic se);
    result_in   = d;
    capture_req = 1'b1;
    scan_enable = se;
    scan_in     = 1'b1;
    tick;
    capture_req = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    check("cap_busy", 192'(busy), 192'(1'b1));
    check("cap_out", 192'(scan_out), 192'(d[0]));
  endtask

  // Shift a full unload, optionally pausing before shift pause_at and
  // raising a capture request on shift ovr_at.
  task automatic shift_all(input logic [TOTAL_W-1:0] d, input int pause_at,
                           input int pause_len, input int ovr_at,
                           input logic [TOTAL_W-1:0] ovr_d);
    logic [L-1:0] got;
    int           ctl_bad;
    int           done_seen;
    logic         hold;
    got       = '0;
    ctl_bad   = 0;
    done_seen = 0;
    for (int n = 0; n < L; n++) begin
      if (n == pause_at) begin
        hold        = scan_out;
        scan_enable = 1'b0;
        for (int k = 0; k < pause_len; k++) begin
          tick;
          if (scan_out !== hold || busy !== 1'b1 || done !== 1'b0) ctl_bad++;
        end
        check("pause_count", 192'(dut.count), 192'(n));
        check("pause_out", 192'(scan_out), 192'(hold));
      end
      got[n]      = scan_out;
      scan_enable = 1'b1;
      if (n == ovr_at) begin
        capture_req = 1'b1;
        result_in   = ovr_d;
      end
      tick;
      capture_req = 1'b0;
      if (done === 1'b1) done_seen++;
      if (n < L - 1 && (busy !== 1'b1 || done !== 1'b0)) ctl_bad++;
    end
    scan_enable = 1'b0;
    last_stream = got;
    check("stream", 192'(got), 192'(expected_stream(d)));
    check("ctl_during_shift", 192'(ctl_bad), 192'(0));
    check("done_pulses", 192'(done_seen), 192'(1));
    check("end_done", 192'(done), 192'(1'b1));
    check("end_busy", 192'(busy), 192'(1'b0));
  endtask

  initial begin
    logic [TOTAL_W-1:0] walk;
    logic [TOTAL_W-1:0] d1;
    logic [TOTAL_W-1:0] d2;
    walk = TOTAL_W'(1) | (TOTAL_W'(3) << 18);
    d1   = {6'h2A, {39{4'hC}}};
    d2   = {6'h15, {39{4'h6}}};

    // Reset with capture and shift requested: both must be ignored.
    reset       = 1'b1;
    capture_req = 1'b1;
    scan_enable = 1'b1;
    scan_in     = 1'b1;
    result_in   = '1;
    tick;
    tick;
    check("rst_busy", 192'(busy), 192'(1'b0));
    check("rst_done", 192'(done), 192'(1'b0));
    check("rst_overrun", 192'(overrun), 192'(1'b0));
    check("rst_scan_out", 192'(scan_out), 192'(1'b0));
    reset       = 1'b0;
    capture_req = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    tick;
    check("idle_busy", 192'(busy), 192'(1'b0));

    // Bypass: a 1 entering at the MSB reaches scan_out after exactly L shifts.
    scan_in     = 1'b1;
    scan_enable = 1'b1;
    for (int i = 0; i < L - 1; i++) tick;
    check("bypass_early", 192'(scan_out), 192'(1'b0));
    check("bypass_busy", 192'(busy), 192'(1'b0));
    tick;
    check("bypass_arrive", 192'(scan_out), 192'(1'b1));
    scan_in     = 1'b0;
    scan_enable = 1'b0;

    // Walking pattern C00=1, C01=3.
    start_capture(walk, 1'b0);
    shift_all(walk, -1, 0, -1, '0);
    tick;
    check("done_fall", 192'(done), 192'(1'b0));
    check("idle_after_done", 192'(busy), 192'(1'b0));

    // All ones with a 10-cycle pause after 50 shifts.
    start_capture('1, 1'b0);
    shift_all('1, 50, 10, -1, '0);
    check("no_overrun", 192'(overrun), 192'(1'b0));
    tick;

    // Overrun at shift 20, then a capture accepted in the DONE cycle.
    start_capture(d1, 1'b0);
    shift_all(d1, -1, 0, 20, d2);
    check("overrun_set", 192'(overrun), 192'(1'b1));
    start_capture(d2, 1'b0);
    shift_all(d2, -1, 0, -1, '0);
    check("overrun_sticky", 192'(overrun), 192'(1'b1));
    tick;

    // Reset in the middle of an unload.
    start_capture(d1, 1'b0);
    scan_enable = 1'b1;
    for (int i = 0; i < 80; i++) tick;
    scan_enable = 1'b0;
    reset       = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", 192'(busy), 192'(1'b0));
    check("abort_scan_out", 192'(scan_out), 192'(1'b0));
    check("abort_overrun", 192'(overrun), 192'(1'b0));
    // Capture together with scan_enable: capture wins, bit 0 of 5 is visible.
    start_capture(TOTAL_W'(5), 1'b1);
    shift_all(TOTAL_W'(5), -1, 0, -1, '0);
    check("h5_bits", 192'(last_stream[3:0]), 192'(4'b0101));
    tick;

`ifdef SCAN_UNLOAD_PARITY_EN
    start_capture(TOTAL_W'(7), 1'b0);
    shift_all(TOTAL_W'(7), -1, 0, -1, '0);
    check("parity_h7", 192'(last_stream[L-1]), 192'(1'b1));
    tick;
    start_capture(TOTAL_W'(3), 1'b0);
    shift_all(TOTAL_W'(3), -1, 0, -1, '0);
    check("parity_h3", 192'(last_stream[L-1]), 192'(1'b0));
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
